// File: rtl/uart_pkg.sv
// Shared UART constants, arbiter state encoding and small helpers.
package uart_pkg;

  localparam int CLK_FREQ     = 100_000_000;
  localparam int BAUD_DEFAULT = 115_200;
  localparam int FRAME_BITS   = 10;
  localparam int BIT_CLKS     = CLK_FREQ / BAUD_DEFAULT;

  // Next power of two above one full frame at the default baud (about 2x margin).
  localparam int TIMEOUT_DEFAULT = 1 << $clog2(FRAME_BITS * BIT_CLKS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_LAUNCH = S_LAUNCH,
    ST_WAIT   = S_WAIT,
    ST_GAP    = S_GAP,
    ST_FAULT  = S_FAULT
  } arb_state_t;

  // One-hot of an index; callers truncate to their own requester count.
  function automatic logic [7:0] onehot8(input int idx);
    onehot8 = 8'd1 << idx;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: searches upward from last+1, wrapping at NREQ-1.
module uart_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   winner,
  output logic            valid
);

  logic [IW-1:0] idx;

  // Walk candidates from farthest to nearest so the nearest pending one wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one uart_tx among NREQ byte producers.
// Optional watchdog compiled in with UART_ARB_WATCHDOG_EN.
//
// state  | meaning
// IDLE   | arbitrate among pending requests, latch winner byte
// LAUNCH | tx_en pulse to uart_tx, active rises
// WAIT   | frame in flight, wait for tx_done (watchdog runs here)
// GAP    | ack pulse cycle, lets the winner drop req before re-arbitration
// FAULT  | watchdog expired, arbitration halted until clr_fault
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [8*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]         ack,
  output logic [NREQ-1:0]         err,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    active,
  output logic                    fault,
  input  logic                    clr_fault,
  output logic                    tx_en,
  output logic [7:0]              tx_data,
  input  logic                    tx_done
);

  localparam int IW = $clog2(NREQ);

  arb_state_t    state;
  logic [IW-1:0] last;
  logic [IW-1:0] pick_id;
  logic          pick_valid;
  logic [7:0]    req_byte [NREQ];

  // Unpack the flat byte bus so the winner index selects directly.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_byte[i] = req_data[8*i +: 8];
    end
  end

  uart_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (req),
    .last   (last),
    .winner (pick_id),
    .valid  (pick_valid)
  );

`ifdef UART_ARB_WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;
  logic [NREQ-1:0] err_q;
  logic            fault_q;
  assign err   = err_q;
  assign fault = fault_q;
`else
  logic unused_cfg;
  assign unused_cfg = clr_fault ^ (TIMEOUT_CYCLES > 0);
  assign err   = '0;
  assign fault = 1'b0;
`endif

  // Arbitration / sequencing FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      last     <= IW'(NREQ - 1);
      grant_id <= '0;
      tx_data  <= '0;
      tx_en    <= 1'b0;
      active   <= 1'b0;
      ack      <= '0;
`ifdef UART_ARB_WATCHDOG_EN
      err_q    <= '0;
      fault_q  <= 1'b0;
      wd_cnt   <= '0;
`endif
    end else begin
      tx_en <= 1'b0;
      ack   <= '0;
`ifdef UART_ARB_WATCHDOG_EN
      err_q <= '0;
`endif
      unique case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_id <= pick_id;
            last     <= pick_id;
            tx_data  <= req_byte[pick_id];
            tx_en    <= 1'b1;
            active   <= 1'b1;
            state    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
`ifdef UART_ARB_WATCHDOG_EN
          // Down-counter loaded on WAIT entry; terminal count 1 marks the last WAIT cycle.
          wd_cnt <= TW'(TIMEOUT_CYCLES);
`endif
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tx_done) begin
            ack    <= NREQ'(onehot8(int'(grant_id)));
            active <= 1'b0;
            state  <= ST_GAP;
          end
`ifdef UART_ARB_WATCHDOG_EN
          else if (wd_cnt == TW'(1)) begin
            err_q   <= NREQ'(onehot8(int'(grant_id)));
            fault_q <= 1'b1;
            active  <= 1'b0;
            state   <= ST_FAULT;
          end else begin
            wd_cnt <= wd_cnt - TW'(1);
          end
`endif
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        ST_FAULT: begin
`ifdef UART_ARB_WATCHDOG_EN
          if (clr_fault) begin
            fault_q <= 1'b0;
            state   <= ST_IDLE;
          end
`else
          state <= ST_IDLE;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
